// File: rtl/tt_chk_pkg.sv
// Shared types and constants for the truth-table response checker.
package tt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {15'b0, d};
  endfunction

endpackage

// File: rtl/tt_misr.sv
// 16-bit MISR compacting one DUT output bit per accepted sample.
module tt_misr
  import tt_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= misr_next(sig, din);
    end
  end

endmodule

// File: rtl/tt_resp_checker.sv
// Checks sampled DUT responses against EXP_TT, tracking coverage, errors and first failure.
// Optional signature compaction is enabled by defining TT_MISR_EN.
//
// state | meaning
// IDLE  | waiting for start, samples ignored
// RUN   | checking samples until every vector has been seen
// DONE  | results held until the next start
module tt_resp_checker
  import tt_chk_pkg::*;
#(
  parameter int                    N_IN   = 4,
  parameter logic [(2**N_IN)-1:0]  EXP_TT = 16'hA5C3,
  parameter int                    CNT_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [N_IN-1:0]        in_vec,
  input  logic                   dut_f,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   first_err_vld,
  output logic [N_IN-1:0]        first_err_vec,
  output logic [(2**N_IN)-1:0]   cov,
  output logic [15:0]            sig
);

  localparam int DEPTH = 2**N_IN;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_t            state_q, state_d;
  logic              clr, accept, mismatch;
  logic [DEPTH-1:0]  vec_bit;
  logic [DEPTH-1:0]  cov_d;
  logic [CNT_W-1:0]  err_d;
  logic              fev_d;
  logic [N_IN-1:0]   fevec_d;

  assign vec_bit = {{(DEPTH-1){1'b0}}, 1'b1} << in_vec;

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    accept   = 1'b0;
    cov_d    = cov;
    err_d    = err_cnt;
    fev_d    = first_err_vld;
    fevec_d  = first_err_vec;
    // Defaulting to mismatch makes an unknown dut_f count as a failure.
    mismatch = 1'b1;
    if (dut_f == EXP_TT[in_vec]) mismatch = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (start) clr = 1'b1;
        else if (in_valid) accept = 1'b1;
      end
      DONE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      cov_d   = '0;
      err_d   = '0;
      fev_d   = 1'b0;
      fevec_d = '0;
    end else if (accept) begin
      cov_d = cov | vec_bit;
      if (mismatch) begin
        if (err_cnt != ERR_MAX) err_d = err_cnt + CNT_W'(1);
        if (!first_err_vld) begin
          fev_d   = 1'b1;
          fevec_d = in_vec;
        end
      end
      if (&cov_d) state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_vec <= '0;
      cov           <= '0;
    end else begin
      state_q       <= state_d;
      busy          <= (state_d == RUN);
      done          <= (state_d == DONE);
      pass          <= (state_d == DONE) && (err_d == '0);
      err_cnt       <= err_d;
      first_err_vld <= fev_d;
      first_err_vec <= fevec_d;
      cov           <= cov_d;
    end
  end

`ifdef TT_MISR_EN
  tt_misr u_misr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (accept),
    .din  (dut_f),
    .sig  (sig)
  );
`else
  assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_tt_resp_checker.sv
// Randomized and directed bench for tt_resp_checker against a behavioural model.
module tb_tt_resp_checker;

  localparam logic [15:0] EXP_TT = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_vec = 4'd0;
  logic        dut_f = 1'b0;
  logic        busy, done, pass, first_err_vld;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_vec;
  logic [15:0] cov, sig;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  logic [15:0] tt = EXP_TT;

  tt_resp_checker #(.N_IN(4), .EXP_TT(EXP_TT), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_vec        (in_vec),
    .dut_f         (dut_f),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_vld (first_err_vld),
    .first_err_vec (first_err_vec),
    .cov           (cov),
    .sig           (sig)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting, 1 = checking, 2 = finished.
  int          m_phase = 0;
  bit          m_seen[16];
  int          m_err = 0;
  bit          m_fev = 0;
  int          m_fevec = 0;
  logic [15:0] m_sig = 16'hFFFF;

  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic d);
    int v;
    v = int'(s) * 2;
    if (v >= 65536) v = v ^ 32'h0001_1021;
    v = v ^ int'(d);
    return v[15:0];
  endfunction

  task automatic model_clear();
    m_err = 0;
    m_fev = 0;
    m_fevec = 0;
    m_sig = 16'hFFFF;
    foreach (m_seen[i]) m_seen[i] = 0;
  endtask

  always @(posedge clk) begin
    int n_seen;
    if (rst) begin
      m_phase = 0;
      model_clear();
    end else if (start) begin
      m_phase = 1;
      model_clear();
    end else if (m_phase == 1 && in_valid) begin
      if (dut_f != tt[in_vec]) begin
        if (m_err < 31) m_err = m_err + 1;
        if (!m_fev) begin
          m_fev = 1;
          m_fevec = int'(in_vec);
        end
      end
      m_seen[in_vec] = 1;
      m_sig = ref_misr(m_sig, dut_f);
      n_seen = 0;
      foreach (m_seen[i]) n_seen += int'(m_seen[i]);
      if (n_seen == 16) m_phase = 2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_sig();
`ifdef TT_MISR_EN
    return m_sig;
`else
    return 16'h0000;
`endif
  endfunction

  always @(negedge clk) begin
    logic [15:0] m_cov;
    if (cmp_en) begin
      foreach (m_seen[i]) m_cov[i] = m_seen[i];
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("pass", 32'(pass), 32'(m_phase == 2 && m_err == 0));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("first_err_vld", 32'(first_err_vld), 32'(m_fev));
      chk("first_err_vec", 32'(first_err_vec), 32'(m_fevec));
      chk("cov", 32'(cov), 32'(m_cov));
      chk("sig", 32'(sig), 32'(exp_sig()));
    end
  end

  task automatic cyc(input bit st, input bit v, input int vec, input bit f, input bit r);
    @(negedge clk);
    rst = r;
    start = st;
    in_valid = v;
    in_vec = vec[3:0];
    dut_f = f;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic sweep(input int bad_a, input int bad_b);
    for (int v = 0; v < 16; v++)
      cyc(0, 1, v, tt[v] ^ ((v == bad_a) || (v == bad_b)), 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    idle();
    cmp_en = 1'b1;
    chk("rst_cov", 32'(cov), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
`ifdef TT_MISR_EN
    chk("rst_sig", 32'(sig), 32'hFFFF);
`else
    chk("rst_sig", 32'(sig), 32'h0);
`endif

    // Sample arriving with start in IDLE is dropped.
    cyc(1, 1, 0, ~tt[0], 0);
    idle();
    chk("start_drop_err", 32'(err_cnt), 32'h0);
    chk("start_drop_cov", 32'(cov), 32'h0);
    chk("start_busy", 32'(busy), 32'h1);

    // Single sample pins the MISR step: FFFF -> FFFE ^ 1021 ^ 1 = EFDE.
    cyc(0, 1, 0, 1, 0);
    idle();
`ifdef TT_MISR_EN
    chk("misr_one_step", 32'(sig), 32'hEFDE);
`else
    chk("misr_absent", 32'(sig), 32'h0);
`endif

    // Golden sweep.
    cyc(1, 0, 0, 0, 0);
    sweep(-1, -1);
    idle();
    chk("golden_done", 32'(done), 32'h1);
    chk("golden_pass", 32'(pass), 32'h1);
    chk("golden_err", 32'(err_cnt), 32'h0);
    chk("golden_cov", 32'(cov), 32'hFFFF);

    // Injected faults at 5 and 9.
    cyc(1, 0, 0, 0, 0);
    sweep(5, 9);
    idle();
    chk("fault_err", 32'(err_cnt), 32'd2);
    chk("fault_fev", 32'(first_err_vld), 32'h1);
    chk("fault_fevec", 32'(first_err_vec), 32'd5);
    chk("fault_pass", 32'(pass), 32'h0);
    chk("fault_done", 32'(done), 32'h1);
    cyc(0, 1, 3, ~tt[3], 0);
    idle();
    chk("done_ignores_err", 32'(err_cnt), 32'd2);

    // Partial coverage with repeats, then completion.
    cyc(1, 0, 0, 0, 0);
    for (int v = 0; v < 15; v++) begin
      cyc(0, 1, v, tt[v], 0);
      cyc(0, 1, v, tt[v], 0);
    end
    idle();
    chk("partial_done", 32'(done), 32'h0);
    chk("partial_cov", 32'(cov), 32'h7FFF);
    cyc(0, 1, 15, tt[15], 0);
    idle();
    chk("partial_complete", 32'(done), 32'h1);

    // Saturation.
    cyc(1, 0, 0, 0, 0);
    repeat (40) cyc(0, 1, 0, ~tt[0], 0);
    idle();
    chk("sat_err", 32'(err_cnt), 32'd31);
    chk("sat_busy", 32'(busy), 32'h1);
    chk("sat_done", 32'(done), 32'h0);

    // Reset mid-run, then samples without start.
    cyc(1, 0, 0, 0, 0);
    for (int v = 0; v < 8; v++) cyc(0, 1, v, ~tt[v], 0);
    cyc(0, 0, 0, 0, 1);
    idle();
    chk("mrst_err", 32'(err_cnt), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_fev", 32'(first_err_vld), 32'h0);
    for (int v = 0; v < 4; v++) cyc(0, 1, v, 1'b1, 0);
    idle();
    chk("mrst_cov_idle", 32'(cov), 32'h0);

    // Randomized traffic including restarts and resets.
    for (int i = 0; i < 4000; i++) begin
      int vec;
      bit r, st, v, f;
      vec = int'($urandom_range(15));
      r   = ($urandom_range(299) == 0);
      st  = ($urandom_range(59) == 0);
      v   = ($urandom_range(3) != 0);
      f   = tt[vec] ^ ($urandom_range(11) == 0);
      cyc(st, v, vec, f, r);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
